// File: rtl/shot_tracker_pkg.sv
// Shared types and constants for shot_tracker: slot record, channel FSM states,
// per-channel blob colours and frame-fade age parameters.
package shot_tracker_pkg;

    localparam int MAX_CHANNELS = 4;
    localparam int AGE_W        = 6;
    localparam logic [AGE_W-1:0] AGE_LIMIT = 6'd63;

    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
        logic [1:0]  ch;
        logic        valid;
    } slot_t;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_HOLD = 1'b1
    } ch_state_e;

    // Index 0 is the rightmost entry: red, green, blue, yellow.
    localparam logic [MAX_CHANNELS-1:0][23:0] CH_COLOUR =
        {24'hFFFF00, 24'h0000FF, 24'h00FF00, 24'hFF0000};

endpackage

// File: rtl/shot_tracker_if.sv
// Gun/raster/pixel bundle for shot_tracker. The master drives triggers and raster
// position; the slave (the tracker) returns pixel colour, status and debug state.
interface shot_tracker_if #(
    parameter int CHANNELS = 2,
    parameter int PTR_W    = 4
);
    logic [CHANNELS-1:0]    trigger;
    logic [11*CHANNELS-1:0] x;
    logic [10*CHANNELS-1:0] y;
    logic [10:0]            hcount;
    logic [9:0]             vcount;
    logic [23:0]            pixel;
    logic [CHANNELS-1:0]    busy;
    logic [8*CHANNELS-1:0]  shot_count;
    logic [PTR_W-1:0]       wr_ptr;
    logic [CHANNELS-1:0]    dbg_pending;

    modport master (
        output trigger, x, y, hcount, vcount,
        input  pixel, busy, shot_count, wr_ptr, dbg_pending
    );

    modport slave (
        input  trigger, x, y, hcount, vcount,
        output pixel, busy, shot_count, wr_ptr, dbg_pending
    );
endinterface

// File: rtl/shot_tracker_blob.sv
// shot_blob: registered coverage test of one ring slot against the raster position;
// emits the slot's channel colour when covered, else 0.
module shot_blob
    import shot_tracker_pkg::*;
#(
    parameter int BLOB_HALF = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  slot_t       slot_i,
    input  logic [10:0] hcount_i,
    input  logic [9:0]  vcount_i,
    output logic [23:0] colour_o
);
    localparam logic signed [11:0] HALF = 12'(BLOB_HALF);

    logic signed [11:0] dx;
    logic signed [11:0] dy;
    logic               hit;
    logic [23:0]        colour_q;

    // Signed 12-bit differences so blobs near the screen edge clip instead of wrapping.
    always_comb begin
        dx  = $signed({1'b0, hcount_i}) - $signed({1'b0, slot_i.x});
        dy  = $signed({2'b00, vcount_i}) - $signed({2'b00, slot_i.y});
        hit = slot_i.valid && (dx < HALF) && (dx > -HALF) && (dy < HALF) && (dy > -HALF);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            colour_q <= '0;
        end else begin
            colour_q <= hit ? CH_COLOUR[slot_i.ch] : 24'h000000;
        end
    end

    assign colour_o = colour_q;

endmodule

// File: rtl/shot_tracker.sv
// shot_tracker: multi-gun debounced shot capture into a shared ring buffer, rendered
// as per-channel coloured blobs. Define SHOT_TRACKER_FADE_EN to age out shots per frame.
module shot_tracker
    import shot_tracker_pkg::*;
#(
    parameter int SHOT_LIMIT = 16,
    parameter int CHANNELS   = 2,
    parameter int HOLDOFF    = 16_250_000,
    parameter int BLOB_HALF  = 8
) (
    input logic           clk,
    input logic           reset,
    shot_tracker_if.slave bus
);
    localparam int PTR_W = $clog2(SHOT_LIMIT);
    localparam int CNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLDOFF - 1);

    ch_state_e           state_q [CHANNELS];
    ch_state_e           state_d [CHANNELS];
    logic [CNT_W-1:0]    cnt_q   [CHANNELS];
    logic [CNT_W-1:0]    cnt_d   [CHANNELS];
    logic [10:0]         hx_q    [CHANNELS];
    logic [10:0]         hx_d    [CHANNELS];
    logic [9:0]          hy_q    [CHANNELS];
    logic [9:0]          hy_d    [CHANNELS];
    logic [7:0]          count_q [CHANNELS];
    logic [7:0]          count_d [CHANNELS];
    logic [CHANNELS-1:0] trig_q, rise, pending_q, pending_d, pend_set, pend_clr;
    logic [CHANNELS-1:0] busy_vec;
    logic [8*CHANNELS-1:0] count_vec;

    logic                wr_en;
    logic [1:0]          wr_ch;
    logic [10:0]         wr_x;
    logic [9:0]          wr_y;
    slot_t               slot_q [SHOT_LIMIT];
    slot_t               slot_d [SHOT_LIMIT];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [23:0]         blob_colour [SHOT_LIMIT];
    logic [23:0]         pixel_q, pixel_d;

`ifdef SHOT_TRACKER_FADE_EN
    logic [AGE_W-1:0]    age_q [SHOT_LIMIT];
    logic [AGE_W-1:0]    age_d [SHOT_LIMIT];
    logic                frame_strobe;
    assign frame_strobe = (bus.hcount == 11'd0) && (bus.vcount == 10'd0);
`endif

    // Channel FSMs: a rise in IDLE captures the position and starts the hold-off;
    // rises seen during HOLD are dropped.
    always_comb begin
        rise     = bus.trigger & ~trig_q;
        pend_set = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            state_d[c] = state_q[c];
            cnt_d[c]   = cnt_q[c];
            hx_d[c]    = hx_q[c];
            hy_d[c]    = hy_q[c];
            count_d[c] = count_q[c];
            case (state_q[c])
                CH_IDLE: begin
                    if (rise[c]) begin
                        state_d[c]  = CH_HOLD;
                        cnt_d[c]    = '0;
                        hx_d[c]     = bus.x[11*c +: 11];
                        hy_d[c]     = bus.y[10*c +: 10];
                        pend_set[c] = 1'b1;
                        if (count_q[c] != 8'hFF) count_d[c] = count_q[c] + 8'd1;
                    end
                end
                CH_HOLD: begin
                    if (cnt_q[c] == CNT_LAST) state_d[c] = CH_IDLE;
                    else                      cnt_d[c]   = cnt_q[c] + 1'b1;
                end
                default: state_d[c] = CH_IDLE;
            endcase
        end
    end

    // Writer: the lowest-index pending channel wins the single write slot.
    always_comb begin
        wr_en    = 1'b0;
        wr_ch    = '0;
        wr_x     = '0;
        wr_y     = '0;
        pend_clr = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (pending_q[c] && !wr_en) begin
                wr_en       = 1'b1;
                wr_ch       = 2'(c);
                wr_x        = hx_q[c];
                wr_y        = hy_q[c];
                pend_clr[c] = 1'b1;
            end
        end
        pending_d = (pending_q & ~pend_clr) | pend_set;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        for (int s = 0; s < SHOT_LIMIT; s++) slot_d[s] = slot_q[s];
`ifdef SHOT_TRACKER_FADE_EN
        for (int s = 0; s < SHOT_LIMIT; s++) begin
            age_d[s] = age_q[s];
            if (frame_strobe && slot_q[s].valid) begin
                age_d[s] = age_q[s] + 1'b1;
                if (age_q[s] == AGE_LIMIT - 6'd1) slot_d[s].valid = 1'b0;
            end
        end
`endif
        // A full ring simply overwrites its oldest entry at wr_ptr.
        if (wr_en) begin
            slot_d[wr_ptr_q] = '{x: wr_x, y: wr_y, ch: wr_ch, valid: 1'b1};
`ifdef SHOT_TRACKER_FADE_EN
            age_d[wr_ptr_q] = '0;
`endif
            wr_ptr_d = (wr_ptr_q == PTR_W'(SHOT_LIMIT - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            trig_q    <= '0;
            pending_q <= '0;
            wr_ptr_q  <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                state_q[c] <= CH_IDLE;
                cnt_q[c]   <= '0;
                hx_q[c]    <= '0;
                hy_q[c]    <= '0;
                count_q[c] <= '0;
            end
            for (int s = 0; s < SHOT_LIMIT; s++) begin
                slot_q[s] <= '0;
`ifdef SHOT_TRACKER_FADE_EN
                age_q[s]  <= '0;
`endif
            end
        end else begin
            trig_q    <= bus.trigger;
            pending_q <= pending_d;
            wr_ptr_q  <= wr_ptr_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hx_q      <= hx_d;
            hy_q      <= hy_d;
            count_q   <= count_d;
            slot_q    <= slot_d;
`ifdef SHOT_TRACKER_FADE_EN
            age_q     <= age_d;
`endif
        end
    end

    for (genvar s = 0; s < SHOT_LIMIT; s++) begin : g_blob
        shot_blob #(.BLOB_HALF(BLOB_HALF)) u_blob (
            .clk      (clk),
            .reset    (reset),
            .slot_i   (slot_q[s]),
            .hcount_i (bus.hcount),
            .vcount_i (bus.vcount),
            .colour_o (blob_colour[s])
        );
    end

    always_comb begin
        pixel_d = '0;
        for (int s = 0; s < SHOT_LIMIT; s++) pixel_d = pixel_d | blob_colour[s];
    end

    always_ff @(posedge clk) begin
        if (reset) pixel_q <= '0;
        else       pixel_q <= pixel_d;
    end

    // busy is the FSM state bit itself (HOLD = 1).
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            busy_vec[c]          = (state_q[c] == CH_HOLD);
            count_vec[8*c +: 8]  = count_q[c];
        end
    end

    assign bus.pixel       = pixel_q;
    assign bus.busy        = busy_vec;
    assign bus.shot_count  = count_vec;
    assign bus.wr_ptr      = wr_ptr_q;
    assign bus.dbg_pending = pending_q;

endmodule

// File: tb/tb_shot_tracker.sv
// Bench for shot_tracker (SHOT_LIMIT=4, CHANNELS=2, HOLDOFF=50); the fade scenario
// is included when SHOT_TRACKER_FADE_EN is defined.
module tb_shot_tracker;

    localparam int SL = 4;
    localparam int CH = 2;
    localparam int HO = 50;
    localparam int BH = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    shot_tracker_if #(.CHANNELS(CH), .PTR_W(2)) bus ();

    shot_tracker #(
        .SHOT_LIMIT (SL),
        .CHANNELS   (CH),
        .HOLDOFF    (HO),
        .BLOB_HALF  (BH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          vectors = 0;
    int          errors  = 0;
    logic [23:0] exp_q[$];

    // Reference ring model
    int m_x[SL], m_y[SL], m_ch[SL], m_age[SL];
    bit m_v[SL];
    int m_ptr;

    function automatic logic [23:0] colour_of(int ch);
        case (ch)
            0:       return 24'hFF0000;
            1:       return 24'h00FF00;
            2:       return 24'h0000FF;
            default: return 24'hFFFF00;
        endcase
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < SL; s++) begin
            m_v[s]   = 1'b0;
            m_age[s] = 0;
        end
        m_ptr = 0;
    endfunction

    function automatic void model_write(int x, int y, int ch);
        m_x[m_ptr]   = x;
        m_y[m_ptr]   = y;
        m_ch[m_ptr]  = ch;
        m_v[m_ptr]   = 1'b1;
        m_age[m_ptr] = 0;
        m_ptr        = (m_ptr + 1) % SL;
    endfunction

    function automatic void model_frame();
        for (int s = 0; s < SL; s++) begin
            if (m_v[s]) begin
                m_age[s]++;
                if (m_age[s] >= 63) m_v[s] = 1'b0;
            end
        end
    endfunction

    function automatic logic [23:0] model_pixel(int hc, int vc);
        logic [23:0] p = '0;
        for (int s = 0; s < SL; s++) begin
            if (m_v[s]) begin
                int dx = hc - m_x[s];
                int dy = vc - m_y[s];
                if (dx < BH && dx > -BH && dy < BH && dy > -BH) p = p | colour_of(m_ch[s]);
            end
        end
        return p;
    endfunction

    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        bus.trigger = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_clear();
    endtask

    task automatic fire(input logic [CH-1:0] mask, input int x0, input int y0,
                        input int x1, input int y1);
        bus.x       = {11'(x1), 11'(x0)};
        bus.y       = {10'(y1), 10'(y0)};
        bus.trigger = mask;
        @(posedge clk);
        #1 bus.trigger = '0;
    endtask

    task automatic render_probe(input int hc, input int vc);
        bus.hcount = 11'(hc);
        bus.vcount = 10'(vc);
        exp_q.push_back(model_pixel(hc, vc));
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int c);
        int n = 0;
        while (bus.busy[c] && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        vectors++;
        if (bus.busy[c]) begin
            errors++;
            $display("FAIL wait_idle ch%0d: busy=%b after %0d cycles, required 0", c, bus.busy[c], n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (bus.pixel !== 24'h0) begin errors++; $display("FAIL reset_pixel: got %h want 000000", bus.pixel); end
        vectors++; if (bus.busy !== 2'b00) begin errors++; $display("FAIL reset_busy: got %b want 00", bus.busy); end
        vectors++; if (bus.shot_count !== 16'h0) begin errors++; $display("FAIL reset_count: got %h want 0000", bus.shot_count); end
        vectors++; if (bus.wr_ptr !== 2'd0) begin errors++; $display("FAIL reset_wr_ptr: got %0d want 0", bus.wr_ptr); end
    endtask

    task automatic test_single_shot();
        int          ph[8] = '{100, 120, 107, 108, 93, 92, 100, 100};
        int          pv[8] = '{200, 200, 200, 200, 200, 200, 207, 208};
        logic [23:0] exp;
        fire(2'b01, 100, 200, 0, 0);
        vectors++; if (bus.busy !== 2'b01) begin errors++; $display("FAIL single_busy: got %b want 01", bus.busy); end
        vectors++; if (bus.wr_ptr !== 2'd0) begin errors++; $display("FAIL single_ptr_pre: got %0d want 0", bus.wr_ptr); end
        vectors++; if (bus.shot_count[7:0] !== 8'd1) begin errors++; $display("FAIL single_count: got %0d want 1", bus.shot_count[7:0]); end
        @(posedge clk);
        #1 model_write(100, 200, 0);
        vectors++; if (bus.wr_ptr !== 2'd1) begin errors++; $display("FAIL single_ptr_post: got %0d want 1", bus.wr_ptr); end
        for (int i = 0; i < 8; i++) begin
            render_probe(ph[i], pv[i]);
            exp = exp_q.pop_front();
            vectors++;
            if (bus.pixel !== exp) begin
                errors++;
                $display("FAIL single_pixel(%0d,%0d): got %h want %h", ph[i], pv[i], bus.pixel, exp);
            end
        end
    endtask

    task automatic test_holdoff();
        logic [23:0] exp;
        wait_idle(0);
        fire(2'b01, 300, 300, 0, 0);
        model_write(300, 300, 0);
        vectors++; if (bus.busy[0] !== 1'b1) begin errors++; $display("FAIL hold_busy_start: got %b want 1", bus.busy[0]); end
        repeat (19) @(posedge clk);
        #1 fire(2'b01, 310, 300, 0, 0);
        vectors++; if (bus.shot_count[7:0] !== 8'd2) begin errors++; $display("FAIL hold_discard_count: got %0d want 2", bus.shot_count[7:0]); end
        vectors++; if (bus.wr_ptr !== 2'd2) begin errors++; $display("FAIL hold_discard_ptr: got %0d want 2", bus.wr_ptr); end
        repeat (29) @(posedge clk);
        #1;
        vectors++; if (bus.busy[0] !== 1'b1) begin errors++; $display("FAIL hold_busy_last: got %b want 1", bus.busy[0]); end
        @(posedge clk);
        #1;
        vectors++; if (bus.busy[0] !== 1'b0) begin errors++; $display("FAIL hold_busy_end: got %b want 0", bus.busy[0]); end
        repeat (9) @(posedge clk);
        #1 fire(2'b01, 330, 300, 0, 0);
        vectors++; if (bus.shot_count[7:0] !== 8'd3) begin errors++; $display("FAIL hold_accept_count: got %0d want 3", bus.shot_count[7:0]); end
        @(posedge clk);
        #1 model_write(330, 300, 0);
        vectors++; if (bus.wr_ptr !== 2'd3) begin errors++; $display("FAIL hold_accept_ptr: got %0d want 3", bus.wr_ptr); end
        render_probe(310, 300);
        exp = exp_q.pop_front();
        vectors++; if (bus.pixel !== exp) begin errors++; $display("FAIL hold_pixel: got %h want %h", bus.pixel, exp); end
    endtask

    task automatic test_simultaneous();
        int          ph[4] = '{402, 396, 410, 402};
        int          pv[4] = '{400, 400, 400, 408};
        logic [23:0] exp;
        do_reset();
        fire(2'b11, 400, 400, 405, 400);
        vectors++; if (bus.busy !== 2'b11) begin errors++; $display("FAIL simul_busy: got %b want 11", bus.busy); end
        vectors++; if (bus.dbg_pending !== 2'b11) begin errors++; $display("FAIL simul_pend0: got %b want 11", bus.dbg_pending); end
        @(posedge clk);
        #1 model_write(400, 400, 0);
        vectors++; if (bus.wr_ptr !== 2'd1) begin errors++; $display("FAIL simul_ptr1: got %0d want 1", bus.wr_ptr); end
        vectors++; if (bus.dbg_pending !== 2'b10) begin errors++; $display("FAIL simul_pend1: got %b want 10", bus.dbg_pending); end
        @(posedge clk);
        #1 model_write(405, 400, 1);
        vectors++; if (bus.wr_ptr !== 2'd2) begin errors++; $display("FAIL simul_ptr2: got %0d want 2", bus.wr_ptr); end
        vectors++; if (bus.shot_count !== 16'h0101) begin errors++; $display("FAIL simul_count: got %h want 0101", bus.shot_count); end
        for (int i = 0; i < 4; i++) begin
            render_probe(ph[i], pv[i]);
            exp = exp_q.pop_front();
            vectors++;
            if (bus.pixel !== exp) begin
                errors++;
                $display("FAIL simul_pixel(%0d,%0d): got %h want %h", ph[i], pv[i], bus.pixel, exp);
            end
        end
    endtask

    task automatic test_wrap();
        logic [23:0] exp;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            wait_idle(i % 2);
            fire((i % 2 == 0) ? 2'b01 : 2'b10, 100 + 100 * i, 100, 100 + 100 * i, 100);
            model_write(100 + 100 * i, 100, i % 2);
        end
        @(posedge clk);
        #1;
        vectors++; if (bus.wr_ptr !== 2'd2) begin errors++; $display("FAIL wrap_ptr: got %0d want 2", bus.wr_ptr); end
        vectors++; if (bus.shot_count !== 16'h0303) begin errors++; $display("FAIL wrap_count: got %h want 0303", bus.shot_count); end
        for (int i = 0; i < 6; i++) begin
            render_probe(100 + 100 * i, 100);
            exp = exp_q.pop_front();
            vectors++;
            if (bus.pixel !== exp) begin
                errors++;
                $display("FAIL wrap_pixel shot%0d: got %h want %h", i + 1, bus.pixel, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [23:0] exp;
        wait_idle(0);
        fire(2'b01, 700, 500, 0, 0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        model_clear();
        vectors++; if (bus.wr_ptr !== 2'd0) begin errors++; $display("FAIL rmid_ptr: got %0d want 0", bus.wr_ptr); end
        vectors++; if (bus.busy !== 2'b00) begin errors++; $display("FAIL rmid_busy: got %b want 00", bus.busy); end
        vectors++; if (bus.shot_count !== 16'h0) begin errors++; $display("FAIL rmid_count: got %h want 0000", bus.shot_count); end
        vectors++; if (bus.dbg_pending !== 2'b00) begin errors++; $display("FAIL rmid_pend: got %b want 00", bus.dbg_pending); end
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (bus.wr_ptr !== 2'd0) begin errors++; $display("FAIL rmid_ptr_late: got %0d want 0", bus.wr_ptr); end
        render_probe(700, 500);
        exp = exp_q.pop_front();
        vectors++; if (bus.pixel !== exp) begin errors++; $display("FAIL rmid_pixel_new: got %h want %h", bus.pixel, exp); end
        render_probe(500, 100);
        exp = exp_q.pop_front();
        vectors++; if (bus.pixel !== exp) begin errors++; $display("FAIL rmid_pixel_old: got %h want %h", bus.pixel, exp); end
    endtask

`ifdef SHOT_TRACKER_FADE_EN
    task automatic test_fade();
        logic [23:0] exp;
        fire(2'b01, 500, 500, 0, 0);
        @(posedge clk);
        #1 model_write(500, 500, 0);
        render_probe(500, 500);
        exp = exp_q.pop_front();
        vectors++; if (bus.pixel !== exp) begin errors++; $display("FAIL fade_fresh: got %h want %h", bus.pixel, exp); end
        bus.hcount = 11'd0;
        bus.vcount = 10'd0;
        repeat (62) begin
            @(posedge clk);
            model_frame();
        end
        #1;
        render_probe(500, 500);
        exp = exp_q.pop_front();
        vectors++; if (bus.pixel !== exp) begin errors++; $display("FAIL fade_62: got %h want %h", bus.pixel, exp); end
        bus.hcount = 11'd0;
        bus.vcount = 10'd0;
        @(posedge clk);
        #1 model_frame();
        render_probe(500, 500);
        exp = exp_q.pop_front();
        vectors++; if (bus.pixel !== exp) begin errors++; $display("FAIL fade_63: got %h want %h", bus.pixel, exp); end
    endtask
`endif

    initial begin
        reset       = 1'b1;
        bus.trigger = '0;
        bus.x       = '0;
        bus.y       = '0;
        bus.hcount  = 11'd1000;
        bus.vcount  = 10'd700;
        model_clear();
        test_reset();
        test_single_shot();
        test_holdoff();
        test_simultaneous();
        test_wrap();
        test_reset_mid();
`ifdef SHOT_TRACKER_FADE_EN
        test_fade();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
